// File: rtl/conv_pkg.sv
// conv_pkg: shared types and default parameters for the 3x3 convolution
// sequencer slice.
//   seq_state_e     : sequencer FSM state encoding
//   DEF_*           : default parameter values used by conv_seq_ctrl
package conv_pkg;

  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_KERNEL_SIZE = 3;
  localparam int DEF_PADDING     = 1;
  localparam int DEF_DIM_BITS    = 10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    KLOAD  = 3'd1,
    STREAM = 3'd2,
    FLUSH  = 3'd3,
    DONE   = 3'd4
  } seq_state_e;

endpackage

// File: rtl/conv_res_slot.sv
// conv_res_slot: one-entry valid/ready holding stage for convolution results.
// The datapath output register is loaded on cap_en; this stage tracks whether
// that register holds a result the downstream has not yet taken.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   cap_pend     a complete window is waiting to be captured
//   cap_last     the pending window is the final one of the job
//   res_ready    downstream accept
//   res_valid    result held for downstream
//   res_last     held result is the final one of the job
//   cap_en       capture strobe to the datapath (conv_valid_out)
//   slot_free    slot can take a new capture this cycle
module conv_res_slot (
  input  logic clk,
  input  logic rst_n,
  input  logic cap_pend,
  input  logic cap_last,
  input  logic res_ready,
  output logic res_valid,
  output logic res_last,
  output logic cap_en,
  output logic slot_free
);

  logic res_valid_q;
  logic res_last_q;

  // A capture may coincide with the downstream taking the previous result.
  assign slot_free = !res_valid_q || res_ready;
  assign cap_en    = cap_pend && slot_free;
  assign res_valid = res_valid_q;
  assign res_last  = res_last_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      res_last_q  <= 1'b0;
    end else if (cap_en) begin
      res_valid_q <= 1'b1;
      res_last_q  <= cap_last;
    end else if (res_ready) begin
      res_valid_q <= 1'b0;
      res_last_q  <= 1'b0;
    end
  end

endmodule

// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl: sequencer for the 3x3 convolution datapath. Loads
// KERNEL_SIZE kernel beats, then streams image columns band by band,
// driving the datapath shift / kernel-load / capture strobes and exposing
// results as a valid/ready stream. The datapath sits outside this block and
// is driven through the conv_* ports.
// Build option: define CONV_SEQ_PAD_EN to inject PADDING zero columns before
// and after each band's real columns.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   start                      begin job (IDLE only)
//   cfg_img_w, cfg_img_h       columns per band, image rows
//   busy, done, cfg_err        job status; done/cfg_err are 1-cycle pulses
//   col_valid/col_ready        upstream column / kernel beat handshake
//   col_data0..2               beat payload (three rows)
//   conv_data0..2              datapath data inputs
//   conv_valid_in              datapath shift strobe
//   conv_kern_ld               datapath kernel load
//   conv_valid_out             datapath result capture strobe
//   res_valid/res_ready        result stream handshake
//   res_last                   final result of the job
//
// state  | meaning
// IDLE   | waiting for start
// KLOAD  | accepting kernel beats
// STREAM | shifting image columns, band by band
// FLUSH  | draining the last capture and held result
// DONE   | one-cycle done (and cfg_err) pulse
module conv_seq_ctrl
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
  parameter int PADDING     = DEF_PADDING,
  parameter int DIM_BITS    = DEF_DIM_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIM_BITS-1:0]   cfg_img_w,
  input  logic [DIM_BITS-1:0]   cfg_img_h,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err,
  input  logic                  col_valid,
  output logic                  col_ready,
  input  logic [DATA_WIDTH-1:0] col_data0,
  input  logic [DATA_WIDTH-1:0] col_data1,
  input  logic [DATA_WIDTH-1:0] col_data2,
  output logic [DATA_WIDTH-1:0] conv_data0,
  output logic [DATA_WIDTH-1:0] conv_data1,
  output logic [DATA_WIDTH-1:0] conv_data2,
  output logic                  conv_valid_in,
  output logic                  conv_kern_ld,
  output logic                  conv_valid_out,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  res_last
);

`ifdef CONV_SEQ_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif
  localparam int PAD = PAD_EN ? PADDING : 0;

  localparam logic [DIM_BITS:0]   PAD2_W = (DIM_BITS+1)'(2 * PAD);
  localparam logic [DIM_BITS:0]   K_W    = (DIM_BITS+1)'(KERNEL_SIZE);
  localparam logic [DIM_BITS:0]   ONE_W  = (DIM_BITS+1)'(1);
  localparam logic [DIM_BITS-1:0] K_D    = DIM_BITS'(KERNEL_SIZE);
  localparam logic [DIM_BITS-1:0] K_M1   = DIM_BITS'(KERNEL_SIZE - 1);
  localparam logic [DIM_BITS-1:0] ONE    = DIM_BITS'(1);

  seq_state_e          state_q, state_d;
  logic [DIM_BITS-1:0] w_q, h_q;
  logic [DIM_BITS-1:0] kcnt_q, col_cnt_q, band_cnt_q;
  logic                cap_pend_q, cap_last_q, err_q;

  logic [DIM_BITS:0]   cfg_len, band_len;
  logic                cfg_bad, last_col, last_band, inject, win_col;
  logic                pass_data, slot_free;

  // Checked against the live config because it is decided on the start edge.
  assign cfg_len = {1'b0, cfg_img_w} + PAD2_W;
  assign cfg_bad = (cfg_len < K_W) || ({1'b0, cfg_img_h} < K_W);

  // col_cnt runs over the padded band: real columns plus injected zeros.
  assign band_len  = {1'b0, w_q} + PAD2_W;
  assign last_col  = ({1'b0, col_cnt_q} == (band_len - ONE_W));
  assign last_band = (band_cnt_q == (h_q - K_D));

`ifdef CONV_SEQ_PAD_EN
  localparam logic [DIM_BITS:0] PAD_W = (DIM_BITS+1)'(PAD);
  assign inject = (state_q == STREAM) &&
                  (({1'b0, col_cnt_q} < PAD_W) ||
                   ({1'b0, col_cnt_q} >= ({1'b0, w_q} + PAD_W)));
`else
  assign inject = 1'b0;
`endif

  // Any column (real or injected) at position >= K-1 completes a window.
  assign win_col = (state_q == STREAM) && conv_valid_in && (col_cnt_q >= K_M1);

  always_comb begin
    state_d       = state_q;
    col_ready     = 1'b0;
    conv_valid_in = 1'b0;
    conv_kern_ld  = 1'b0;
    pass_data     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = cfg_bad ? DONE : KLOAD;
      end
      KLOAD: begin
        col_ready     = 1'b1;
        pass_data     = 1'b1;
        conv_valid_in = col_valid;
        conv_kern_ld  = col_valid;
        if (col_valid && (kcnt_q == K_M1)) state_d = STREAM;
      end
      STREAM: begin
        // Shifting is held off while an uncaptured window would be lost;
        // shifting on the capture edge itself is safe.
        if (inject) begin
          conv_valid_in = slot_free;
        end else begin
          col_ready     = slot_free;
          pass_data     = 1'b1;
          conv_valid_in = col_valid && slot_free;
        end
        if (conv_valid_in && last_col && last_band) state_d = FLUSH;
      end
      FLUSH: begin
        if (!cap_pend_q && !res_valid) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      w_q        <= '0;
      h_q        <= '0;
      kcnt_q     <= '0;
      col_cnt_q  <= '0;
      band_cnt_q <= '0;
      cap_pend_q <= 1'b0;
      cap_last_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            w_q        <= cfg_img_w;
            h_q        <= cfg_img_h;
            err_q      <= cfg_bad;
            kcnt_q     <= '0;
            col_cnt_q  <= '0;
            band_cnt_q <= '0;
          end
        end
        KLOAD: begin
          if (col_valid) kcnt_q <= kcnt_q + ONE;
        end
        STREAM: begin
          if (conv_valid_in) begin
            if (last_col) begin
              col_cnt_q  <= '0;
              band_cnt_q <= band_cnt_q + ONE;
            end else begin
              col_cnt_q <= col_cnt_q + ONE;
            end
          end
        end
        default: ;
      endcase
      if (win_col) begin
        cap_pend_q <= 1'b1;
        cap_last_q <= last_col && last_band;
      end else if (conv_valid_out) begin
        cap_pend_q <= 1'b0;
      end
    end
  end

  conv_res_slot u_res_slot (
    .clk       (clk),
    .rst_n     (rst_n),
    .cap_pend  (cap_pend_q),
    .cap_last  (cap_last_q),
    .res_ready (res_ready),
    .res_valid (res_valid),
    .res_last  (res_last),
    .cap_en    (conv_valid_out),
    .slot_free (slot_free)
  );

  assign conv_data0 = pass_data ? col_data0 : '0;
  assign conv_data1 = pass_data ? col_data1 : '0;
  assign conv_data2 = pass_data ? col_data2 : '0;

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign cfg_err = (state_q == DONE) && err_q;

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Testbench for conv_seq_ctrl: table of job vectors plus random jobs, each
// checked against golden 3x3 sums of products computed from the image and
// kernel, with a small model of the external datapath driven by the conv_*
// strobes. Honours CONV_SEQ_PAD_EN.
`timescale 1ns/1ps
module tb_conv_seq_ctrl;

`ifdef CONV_SEQ_PAD_EN
  localparam int PAD = 1;
`else
  localparam int PAD = 0;
`endif
  localparam int K = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  cfg_img_w = '0, cfg_img_h = '0;
  logic        busy, done, cfg_err;
  logic        col_valid = 1'b0;
  logic        col_ready;
  logic [15:0] col_data0 = '0, col_data1 = '0, col_data2 = '0;
  logic [15:0] conv_data0, conv_data1, conv_data2;
  logic        conv_valid_in, conv_kern_ld, conv_valid_out;
  logic        res_valid, res_last;
  logic        res_ready = 1'b0;

  always #5 clk = ~clk;

  conv_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_img_w(cfg_img_w), .cfg_img_h(cfg_img_h),
    .busy(busy), .done(done), .cfg_err(cfg_err),
    .col_valid(col_valid), .col_ready(col_ready),
    .col_data0(col_data0), .col_data1(col_data1), .col_data2(col_data2),
    .conv_data0(conv_data0), .conv_data1(conv_data1), .conv_data2(conv_data2),
    .conv_valid_in(conv_valid_in), .conv_kern_ld(conv_kern_ld),
    .conv_valid_out(conv_valid_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_last(res_last)
  );

  typedef struct { logic [15:0] d0; logic [15:0] d1; logic [15:0] d2; } beat_t;
  typedef struct { int v; bit last; } res_t;
  typedef struct { int w; int h; int mode; int exp_res; bit exp_err; int abort_at; } job_vec_t;

  int nvec = 0;
  int nerr = 0;

  // External datapath model: window/kernel shift registers plus output reg.
  int win [3][3];
  int kq  [3][3];
  int dp_out = 0;
  int img [16][16];
  int kern[3][3];

  task automatic chk(input string name, input longint act, input longint exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int dot();
    int s = 0;
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < 3; r++)
        s += win[c][r] * kq[c][r];
    return s;
  endfunction

  task automatic pulse_reset();
    rst_n = 1'b0; start = 1'b0; col_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // mode 0: res_ready=1; 1: random res_ready and start; 2: hold first result 4 cycles
  task automatic run_job(input int w, input int h, input int mode, input int exp_res,
                         input bit exp_err, input int abort_at);
    beat_t beats[$];
    res_t  expq[$];
    beat_t bt;
    res_t  rt;
    int L, bi, nres, ncap, ninj, cyc, last_hs, stall_cnt, s, x, px;
    bit merr, seen_done, prev_hold;
    L    = w + 2 * PAD;
    merr = (h < K) || (L < K);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        img[r][c] = $urandom_range(0, 255);
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < 3; r++)
        kern[c][r] = $urandom_range(0, 255);
    if (!merr) begin
      for (int c = 0; c < 3; c++) begin
        bt.d0 = 16'(kern[c][0]); bt.d1 = 16'(kern[c][1]); bt.d2 = 16'(kern[c][2]);
        beats.push_back(bt);
      end
      for (int b = 0; b <= h - K; b++)
        for (int c = 0; c < w; c++) begin
          bt.d0 = 16'(img[b][c]); bt.d1 = 16'(img[b+1][c]); bt.d2 = 16'(img[b+2][c]);
          beats.push_back(bt);
        end
      for (int b = 0; b <= h - K; b++)
        for (int j = 0; j <= L - K; j++) begin
          s = 0;
          for (int c = 0; c < 3; c++)
            for (int r = 0; r < 3; r++) begin
              x  = j + c - PAD;
              px = (x >= 0 && x < w) ? img[b+r][x] : 0;
              s += px * kern[c][r];
            end
          rt.v = s; rt.last = (b == h - K) && (j == L - K);
          expq.push_back(rt);
        end
    end
    cfg_img_w = 10'(w); cfg_img_h = 10'(h);
    bi = 0; nres = 0; ncap = 0; ninj = 0; cyc = 0; last_hs = -100; stall_cnt = 0;
    seen_done = 1'b0; prev_hold = 1'b0;
    while (!seen_done && cyc < 1500) begin
      start = (cyc == 0) ? 1'b1 : ((mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0);
      if (bi < beats.size()) begin
        col_valid = ($urandom_range(0, 3) != 0);
        bt = beats[bi];
        col_data0 = bt.d0; col_data1 = bt.d1; col_data2 = bt.d2;
      end else begin
        col_valid = 1'($urandom_range(0, 1));
        col_data0 = 16'($urandom); col_data1 = 16'($urandom); col_data2 = 16'($urandom);
      end
      case (mode)
        0:       res_ready = 1'b1;
        1:       res_ready = 1'($urandom_range(0, 1));
        default: res_ready = !(res_valid && stall_cnt < 4);
      endcase
      @(negedge clk);
      if (!busy && col_valid) chk("idle_col_ready", col_ready, 0);
      if (prev_hold) chk("res_hold", res_valid, 1);
      if (res_valid && !res_ready) chk("stall", {conv_valid_out, col_ready}, 0);
      if (cfg_err && !done) chk("err_without_done", cfg_err, 0);
      if (col_valid && col_ready) begin
        chk("beat_avail", bi < beats.size(), 1);
        chk("col_pass", {conv_valid_in, conv_data0, conv_data1, conv_data2},
            {1'b1, col_data0, col_data1, col_data2});
        chk("kern_ld", conv_kern_ld, bi < K);
        bi++;
      end else if (conv_valid_in) begin
        ninj++;
        chk("inject", {col_ready, conv_kern_ld, conv_data0, conv_data1, conv_data2}, 0);
      end
      if (res_valid && res_ready) begin
        if (expq.size() == 0) chk("extra_result", res_valid, 0);
        else begin
          rt = expq.pop_front();
          chk("res_data", dp_out, rt.v);
          chk("res_last", res_last, rt.last);
        end
        nres++;
        last_hs = cyc;
      end
      if (conv_valid_out) begin
        ncap++;
        dp_out = dot();
      end
      if (conv_valid_in) begin
        if (conv_kern_ld) begin
          kq[0] = kq[1]; kq[1] = kq[2];
          kq[2][0] = int'(conv_data0); kq[2][1] = int'(conv_data1); kq[2][2] = int'(conv_data2);
        end else begin
          win[0] = win[1]; win[1] = win[2];
          win[2][0] = int'(conv_data0); win[2][1] = int'(conv_data1); win[2][2] = int'(conv_data2);
        end
      end
      if (done) begin
        seen_done = 1'b1;
        chk("cfg_err", cfg_err, exp_err);
        if (merr) chk("err_latency", cyc, 1);
        else      chk("done_latency", cyc - last_hs, 2);
      end
      prev_hold = res_valid && !res_ready;
      if (mode >= 2 && res_valid && !res_ready) stall_cnt++;
      if (abort_at > 0 && cyc == abort_at) begin
        pulse_reset();
        @(negedge clk);
        chk("rst_outputs", {busy, done, cfg_err, col_ready, conv_valid_in, conv_kern_ld,
                            conv_valid_out, res_valid, res_last,
                            conv_data0 | conv_data1 | conv_data2}, 0);
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          chk("no_done_after_rst", {done, busy}, 0);
        end
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    col_valid = 1'b0;
    chk("job_done_seen", seen_done, 1);
    chk("res_count", nres, exp_res);
    chk("cap_count", ncap, exp_res);
    chk("beats_used", bi, beats.size());
    chk("inject_count", ninj, merr ? 0 : (h - K + 1) * 2 * PAD);
    @(negedge clk);
    chk("done_pulse", {done, busy}, 0);
    @(posedge clk); #1;
    if (!seen_done) pulse_reset();
  endtask

  initial begin
    job_vec_t vecs[9];
    int w, h, m, er;
    bit me;
`ifdef CONV_SEQ_PAD_EN
    vecs[0] = '{5, 3, 0, 5, 1'b0, 0};
    vecs[1] = '{4, 5, 0, 12, 1'b0, 0};
    vecs[2] = '{6, 4, 2, 12, 1'b0, 0};
    vecs[3] = '{0, 5, 0, 0, 1'b1, 0};
    vecs[4] = '{6, 5, 1, 0, 1'b0, 15};
    vecs[5] = '{5, 4, 1, 10, 1'b0, 0};
    vecs[6] = '{4, 3, 0, 4, 1'b0, 0};
    vecs[7] = '{1, 3, 1, 1, 1'b0, 0};
    vecs[8] = '{5, 2, 0, 0, 1'b1, 0};
`else
    vecs[0] = '{5, 3, 0, 3, 1'b0, 0};
    vecs[1] = '{4, 5, 0, 6, 1'b0, 0};
    vecs[2] = '{6, 4, 2, 8, 1'b0, 0};
    vecs[3] = '{2, 5, 0, 0, 1'b1, 0};
    vecs[4] = '{6, 5, 1, 0, 1'b0, 15};
    vecs[5] = '{5, 4, 1, 6, 1'b0, 0};
    vecs[6] = '{3, 3, 1, 1, 1'b0, 0};
    vecs[7] = '{3, 7, 2, 5, 1'b0, 0};
    vecs[8] = '{5, 2, 0, 0, 1'b1, 0};
`endif
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < 3; r++) begin
        win[c][r] = 0; kq[c][r] = 0;
      end
    // Reset with busy-looking inputs applied.
    rst_n = 1'b0; start = 1'b1; col_valid = 1'b1; res_ready = 1'b1;
    col_data0 = 16'hA5A5; col_data1 = 16'h5A5A; col_data2 = 16'h1234;
    cfg_img_w = 10'd5; cfg_img_h = 10'd3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {busy, done, cfg_err, col_ready, conv_valid_in, conv_kern_ld,
                        conv_valid_out, res_valid, res_last,
                        conv_data0 | conv_data1 | conv_data2}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; start = 1'b0; col_valid = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++)
      run_job(vecs[i].w, vecs[i].h, vecs[i].mode, vecs[i].exp_res,
              vecs[i].exp_err, vecs[i].abort_at);

    for (int i = 0; i < 20; i++) begin
      w  = $urandom_range(0, 9);
      h  = $urandom_range(1, 7);
      m  = $urandom_range(0, 2);
      me = (h < K) || (w + 2 * PAD < K);
      er = me ? 0 : (h - K + 1) * (w + 2 * PAD - K + 1);
      run_job(w, h, m, er, me, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
